// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator computer.
// Outputs are Moore-decoded from the state plus the current IR contents.
module control_unit #(
  parameter int MEM_LAT       = 1,
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic [15:0] i_ir,
  input  logic        i_acc_zero,
  output logic [15:0] o_operand_addr,
  output logic        o_pc_we,
  output logic        o_pc_sel,
  output logic        o_mar_we,
  output logic        o_mar_sel,
  output logic        o_ir_we,
  output logic        o_mbr_we,
  output logic        o_acc_we,
  output logic        o_acc_sel,
  output logic        o_mem_we,
  output logic [3:0]  o_alu_op,
  output logic        o_halted,
  output logic [3:0]  o_state
);

  localparam logic [3:0] S_IDLE = 4'h0;
  localparam logic [3:0] S_F0   = 4'h1;
  localparam logic [3:0] S_F1   = 4'h2;
  localparam logic [3:0] S_F2   = 4'h3;
  localparam logic [3:0] S_D    = 4'h4;
  localparam logic [3:0] S_E0   = 4'h5;
  localparam logic [3:0] S_E1   = 4'h6;
  localparam logic [3:0] S_E2   = 4'h7;
  localparam logic [3:0] S_E3   = 4'h8;
  localparam logic [3:0] S_S0   = 4'h9;
  localparam logic [3:0] S_S1   = 4'hA;
  localparam logic [3:0] S_H    = 4'hF;

  localparam logic [7:0] WAIT_INIT = 8'(MEM_LAT - 1);

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [7:0] r_wait;
  logic [7:0] w_next_wait;
  logic [3:0] w_op;

  assign w_op           = i_ir[15:12];
  assign o_operand_addr = (w_op == 4'h3) ? {8'h00, i_ir[7:0]} : {4'h0, i_ir[11:0]};
  assign o_state        = r_state;

  // State register and memory wait counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_wait  <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_next_wait;
    end
  end

  // Next-state selection; the counter is reloaded whenever a memory wait begins
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_next_state = S_F0;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_F0: begin
        w_next_state = S_F1;
        w_next_wait  = WAIT_INIT;
      end
      S_F1: begin
        if (r_wait == 8'h00) begin
          w_next_state = S_F2;
        end else begin
          w_next_wait = r_wait - 8'h01;
        end
      end
      S_F2: w_next_state = S_D;
      S_D: begin
        case (w_op)
          4'h0, 4'h4, 4'h5: w_next_state = S_F0;
          4'h1, 4'h3:       w_next_state = S_E0;
          4'h2:             w_next_state = S_S0;
          4'hF:             w_next_state = S_H;
          default:          w_next_state = HALT_ON_UNDEF ? S_H : S_F0;
        endcase
      end
      S_E0: begin
        w_next_state = S_E1;
        w_next_wait  = WAIT_INIT;
      end
      S_E1: begin
        if (r_wait == 8'h00) begin
          w_next_state = S_E2;
        end else begin
          w_next_wait = r_wait - 8'h01;
        end
      end
      S_E2:    w_next_state = S_E3;
      S_E3:    w_next_state = S_F0;
      S_S0:    w_next_state = S_S1;
      S_S1:    w_next_state = S_F0;
      S_H:     w_next_state = S_H;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath strobes and selects for the current state
  always_comb begin
    o_pc_we   = 1'b0;
    o_pc_sel  = 1'b0;
    o_mar_we  = 1'b0;
    o_mar_sel = 1'b0;
    o_ir_we   = 1'b0;
    o_mbr_we  = 1'b0;
    o_acc_we  = 1'b0;
    o_acc_sel = 1'b0;
    o_mem_we  = 1'b0;
    o_alu_op  = 4'h0;
    o_halted  = 1'b0;
    case (r_state)
      S_F0: o_mar_we = 1'b1;
      S_F2: begin
        o_ir_we  = 1'b1;
        o_mbr_we = 1'b1;
        o_pc_we  = 1'b1;
      end
      S_D: begin
        if (w_op == 4'h4) begin
          o_pc_we  = 1'b1;
          o_pc_sel = 1'b1;
        end else if (w_op == 4'h5) begin
          o_pc_we  = i_acc_zero;
          o_pc_sel = 1'b1;
        end else begin
          o_pc_we  = 1'b0;
          o_pc_sel = 1'b0;
        end
      end
      S_E0, S_S0: begin
        o_mar_we  = 1'b1;
        o_mar_sel = 1'b1;
      end
      S_E2: o_mbr_we = 1'b1;
      S_E3: begin
        o_acc_we = 1'b1;
        if (w_op == 4'h3) begin
          o_acc_sel = 1'b1;
          o_alu_op  = i_ir[11:8];
        end else begin
          o_acc_sel = 1'b0;
          o_alu_op  = 4'h0;
        end
      end
      S_S1:    o_mem_we = 1'b1;
      S_H:     o_halted = 1'b1;
      default: o_halted = 1'b0;
    endcase
  end

endmodule
